// File: rtl/jedro_1_dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_dmem_arb_pkg
// Shared types for the jedro_1 data-memory arbiter: requester ids and the
// response-pipe slot that tracks which requester issued an in-flight read.
// -----------------------------------------------------------------------------
package jedro_1_dmem_arb_pkg;

   typedef logic req_id_t;

   localparam req_id_t ID_LSU = 1'b0;   // core load/store unit
   localparam req_id_t ID_DBG = 1'b1;   // debug / DMA port

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rsp_slot_t;

endpackage

// File: rtl/jedro_1_rsp_pipe.sv
// -----------------------------------------------------------------------------
// jedro_1_rsp_pipe
// DEPTH-stage shift register of response slots. A slot entering at slot_i
// appears at slot_o exactly DEPTH clocks later, matching the RAM read latency.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high clear (discards in-flight responses)
//   slot_i - {valid, id} of the transfer granted this cycle
//   slot_o - {valid, id} of the read whose data is on the RAM output now
// -----------------------------------------------------------------------------
module jedro_1_rsp_pipe
   import jedro_1_dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  rsp_slot_t slot_i,
   output rsp_slot_t slot_o
);

   rsp_slot_t stage_q [DEPTH];

   // Shift the slot chain one stage per clock; clear every stage on reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= slot_i;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign slot_o = stage_q[DEPTH-1];

endmodule

// File: rtl/jedro_1_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// jedro_1_dmem_arbiter
// Shares one single-port byte-writable data RAM between the jedro_1 LSU (m0)
// and a debug/DMA port (m1). One transfer is granted per cycle, round-robin,
// with an optional lock that keeps ownership for atomic multi-beat sequences.
// Read responses are routed back to their issuer after RD_LATENCY cycles.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   mX_req_i/we_i/addr_i/
//   mX_wdata_i/lock_i         - requester X transfer request (we==0 is a read)
//   mX_gnt_o                  - transfer accepted this cycle (combinational)
//   mX_rvalid_o/rdata_o       - read response for requester X
//   mem_en_o/we_o/addr_o/
//   mem_wdata_o/rdata_i       - RAM interface
// -----------------------------------------------------------------------------
module jedro_1_dmem_arbiter
   import jedro_1_dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    m0_req_i,
   input  logic [DATA_WIDTH/8-1:0] m0_we_i,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   input  logic                    m0_lock_i,
   output logic                    m0_gnt_o,
   output logic                    m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   input  logic                    m1_req_i,
   input  logic [DATA_WIDTH/8-1:0] m1_we_i,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   input  logic                    m1_lock_i,
   output logic                    m1_gnt_o,
   output logic                    m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   output logic                    mem_en_o,
   output logic [DATA_WIDTH/8-1:0] mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t state_q, state_d;
   req_id_t     owner_q, owner_d;
   req_id_t     last_q, last_d;
   req_id_t     gnt_id;
   logic        gnt_m0, gnt_m1;
   logic        rr_m0, rr_m1;
   logic        owner_req;
   logic        lock_sel;
   rsp_slot_t   slot_in, slot_out;

   // Round-robin candidates: a lone request wins, a tie goes to whoever was
   // not granted last.
   assign rr_m0 = m0_req_i & (~m1_req_i | (last_q == ID_DBG));
   assign rr_m1 = m1_req_i & (~m0_req_i | (last_q == ID_LSU));

   // Grant selection and next lock/owner/last state.
   always_comb begin
      gnt_m0    = 1'b0;
      gnt_m1    = 1'b0;
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      owner_req = (owner_q == ID_DBG) ? m1_req_i : m0_req_i;

      if (rst_i) begin
         gnt_m0 = 1'b0;
         gnt_m1 = 1'b0;
      end else begin
         case (state_q)
            LOCKED: begin
               // An owner that stops requesting abandons the lock; the cycle
               // is then arbitrated as if unlocked.
               if (owner_req) begin
                  gnt_m0 = (owner_q == ID_LSU);
                  gnt_m1 = (owner_q == ID_DBG);
               end else begin
                  gnt_m0 = rr_m0;
                  gnt_m1 = rr_m1;
               end
            end
            UNLOCKED: begin
               gnt_m0 = rr_m0;
               gnt_m1 = rr_m1;
            end
            default: begin
               gnt_m0 = 1'b0;
               gnt_m1 = 1'b0;
            end
         endcase
      end

      gnt_id   = gnt_m1 ? ID_DBG : ID_LSU;
      lock_sel = gnt_m1 ? m1_lock_i : m0_lock_i;

      // A locked owner always gets granted while requesting, so "no grant"
      // also covers the abandoned-lock release.
      if (gnt_m0 | gnt_m1) begin
         last_d  = gnt_id;
         owner_d = gnt_id;
         state_d = lock_sel ? LOCKED : UNLOCKED;
      end else begin
         state_d = UNLOCKED;
      end
   end

   // Lock state, lock owner and last-granted requester.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= UNLOCKED;
         owner_q <= ID_LSU;
         last_q  <= ID_DBG;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Steer the granted requester onto the RAM port; idle port is all zero.
   always_comb begin
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (gnt_m1) begin
         mem_we_o    = m1_we_i;
         mem_addr_o  = m1_addr_i;
         mem_wdata_o = m1_wdata_i;
      end else if (gnt_m0) begin
         mem_we_o    = m0_we_i;
         mem_addr_o  = m0_addr_i;
         mem_wdata_o = m0_wdata_i;
      end else begin
         mem_we_o    = '0;
         mem_addr_o  = '0;
         mem_wdata_o = '0;
      end
   end

   assign mem_en_o = gnt_m0 | gnt_m1;
   assign m0_gnt_o = gnt_m0;
   assign m1_gnt_o = gnt_m1;

   assign slot_in.valid = mem_en_o & (mem_we_o == '0);
   assign slot_in.id    = gnt_id;

   jedro_1_rsp_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_rsp_pipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .slot_i (slot_in),
      .slot_o (slot_out)
   );

   assign m0_rvalid_o = slot_out.valid & (slot_out.id == ID_LSU);
   assign m1_rvalid_o = slot_out.valid & (slot_out.id == ID_DBG);
   assign m0_rdata_o  = mem_rdata_i;
   assign m1_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_dmem_arbiter
// Drives two arbiter instances (RD_LATENCY 1 and 3) with identical requester
// stimulus, each backed by its own behavioural RAM. A reference arbitration
// model predicts grants and RAM-port values each cycle; predicted reads are
// queued with their due cycle and compared when the response should appear.
// -----------------------------------------------------------------------------
module tb_jedro_1_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [3:0]  m0_we, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

   logic        gnt0_1, gnt1_1, rv0_1, rv1_1, en_1;
   logic [3:0]  we_1;
   logic [31:0] rd0_1, rd1_1, addr_1, wdata_1, rdata_1;
   logic        gnt0_3, gnt1_3, rv0_3, rv1_3, en_3;
   logic [3:0]  we_3;
   logic [31:0] rd0_3, rd1_3, addr_3, wdata_3, rdata_3;

   typedef struct {
      int          due;
      bit          id;
      logic [31:0] data;
   } exp_t;

   exp_t        sb1[$];
   exp_t        sb3[$];
   logic [31:0] ref_mem [64];
   bit          ref_locked, ref_owner, ref_last;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   jedro_1_dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_lock_i(m0_lock), .m0_gnt_o(gnt0_1), .m0_rvalid_o(rv0_1), .m0_rdata_o(rd0_1),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_lock_i(m1_lock), .m1_gnt_o(gnt1_1), .m1_rvalid_o(rv1_1), .m1_rdata_o(rd1_1),
      .mem_en_o(en_1), .mem_we_o(we_1), .mem_addr_o(addr_1), .mem_wdata_o(wdata_1),
      .mem_rdata_i(rdata_1));

   jedro_1_dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_lock_i(m0_lock), .m0_gnt_o(gnt0_3), .m0_rvalid_o(rv0_3), .m0_rdata_o(rd0_3),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_lock_i(m1_lock), .m1_gnt_o(gnt1_3), .m1_rvalid_o(rv1_3), .m1_rdata_o(rd1_3),
      .mem_en_o(en_3), .mem_we_o(we_3), .mem_addr_o(addr_3), .mem_wdata_o(wdata_3),
      .mem_rdata_i(rdata_3));

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'h0000_FFFF : (32'hA500_0000 | 32'(i));
   endfunction

   // Behavioural RAMs: one read-latency cycle and three respectively.
   logic [31:0] ram1 [64];
   logic [31:0] ram1_rd;
   logic [31:0] ram3 [64];
   logic [31:0] ram3_rd [3];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram1[i] <= init_word(i);
         ram1_rd <= 32'h0;
      end else if (en_1) begin
         if (we_1 == 4'b0000) ram1_rd <= ram1[addr_1[7:2]];
         else for (int b = 0; b < 4; b++)
            if (we_1[b]) ram1[addr_1[7:2]][8*b +: 8] <= wdata_1[8*b +: 8];
      end
   end
   assign rdata_1 = ram1_rd;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram3[i] <= init_word(i);
      end else if (en_3 && we_3 != 4'b0000) begin
         for (int b = 0; b < 4; b++)
            if (we_3[b]) ram3[addr_3[7:2]][8*b +: 8] <= wdata_3[8*b +: 8];
      end
      ram3_rd[0] <= (!rst && en_3 && we_3 == 4'b0000) ? ram3[addr_3[7:2]] : 32'h0;
      ram3_rd[1] <= ram3_rd[0];
      ram3_rd[2] <= ram3_rd[1];
   end
   assign rdata_3 = ram3_rd[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_rsp(input int lat, input logic v0, input logic v1,
                          input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      bit   hit = 1'b0;
      e.id = 1'b0;
      e.data = 32'h0;
      if (lat == 1) begin
         if (sb1.size() > 0 && sb1[0].due == cyc) begin e = sb1.pop_front(); hit = 1'b1; end
      end else begin
         if (sb3.size() > 0 && sb3[0].due == cyc) begin e = sb3.pop_front(); hit = 1'b1; end
      end
      chk($sformatf("L%0d_rvalid0", lat), v0, hit && !e.id);
      chk($sformatf("L%0d_rvalid1", lat), v1, hit && e.id);
      if (hit) chk($sformatf("L%0d_rdata", lat), e.id ? d1 : d0, e.data);
   endtask

   task automatic set_m0(input logic r, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic l);
      m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_lock = l;
   endtask

   task automatic set_m1(input logic r, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic l);
      m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_lock = l;
   endtask

   // One cycle: predict, check combinational and response outputs, clock,
   // then advance the reference model and queue expected read data.
   task automatic step(output bit g0, output bit g1);
      bit          oreq;
      logic [3:0]  xwe;
      logic [31:0] xaddr, xwdata;
      exp_t        e;
      if (rst) begin
         sb1.delete();
         sb3.delete();
      end
      #1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst) begin
         oreq = ref_owner ? m1_req : m0_req;
         if (ref_locked && oreq) begin
            g0 = !ref_owner; g1 = ref_owner;
         end else if (m0_req && m1_req) begin
            g0 = ref_last; g1 = !ref_last;
         end else begin
            g0 = m0_req; g1 = m1_req;
         end
      end
      xwe    = g1 ? m1_we    : (g0 ? m0_we    : 4'h0);
      xaddr  = g1 ? m1_addr  : (g0 ? m0_addr  : 32'h0);
      xwdata = g1 ? m1_wdata : (g0 ? m0_wdata : 32'h0);

      chk("L1_gnt0", gnt0_1, g0);   chk("L3_gnt0", gnt0_3, g0);
      chk("L1_gnt1", gnt1_1, g1);   chk("L3_gnt1", gnt1_3, g1);
      chk("L1_en", en_1, g0 | g1);  chk("L3_en", en_3, g0 | g1);
      chk("L1_we", we_1, xwe);      chk("L3_we", we_3, xwe);
      chk("L1_addr", addr_1, xaddr);   chk("L3_addr", addr_3, xaddr);
      chk("L1_wdata", wdata_1, xwdata); chk("L3_wdata", wdata_3, xwdata);
      chk_rsp(1, rv0_1, rv1_1, rd0_1, rd1_1);
      chk_rsp(3, rv0_3, rv1_3, rd0_3, rd1_3);

      @(posedge clk);
      if (rst) begin
         ref_locked = 1'b0; ref_owner = 1'b0; ref_last = 1'b1;
         for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      end else if (g0 || g1) begin
         ref_last   = g1;
         ref_owner  = g1;
         ref_locked = g1 ? m1_lock : m0_lock;
         if (xwe == 4'h0) begin
            e.id = g1;
            e.data = ref_mem[xaddr[7:2]];
            e.due = cyc + 1; sb1.push_back(e);
            e.due = cyc + 3; sb3.push_back(e);
         end else begin
            for (int b = 0; b < 4; b++)
               if (xwe[b]) ref_mem[xaddr[7:2]][8*b +: 8] = xwdata[8*b +: 8];
         end
      end else begin
         ref_locked = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_both();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      bit g0, g1;
      int beat;
      rst = 1'b1;
      idle_both();
      @(negedge clk);
      step(g0, g1);
      // Requests while in reset must produce nothing.
      set_m0(1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
      set_m1(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
      step(g0, g1);
      rst = 1'b0;
      idle_both();
      step(g0, g1);

      // Contention: alternating grants starting with m0.
      set_m0(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
      set_m1(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
      repeat (4) step(g0, g1);
      idle_both();
      repeat (3) step(g0, g1);

      // Single read of the preloaded word.
      set_m0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
      step(g0, g1);
      idle_both();
      repeat (4) step(g0, g1);

      // Locked three-beat write burst from m1 while m0 keeps requesting.
      beat = 0;
      for (int n = 0; n < 12 && beat < 3; n++) begin
         set_m0(1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
         set_m1(1'b1, 4'b0011, 32'h20 + 32'(4 * beat), 32'h1234_FFFF, beat < 2);
         step(g0, g1);
         if (g1) beat++;
      end
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      step(g0, g1);
      idle_both();
      repeat (2) step(g0, g1);
      // Read back the partially written words.
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b0); step(g0, g1);
      set_m1(1'b1, 4'h0, 32'h28, 32'h0, 1'b0); step(g0, g1);
      idle_both();
      repeat (4) step(g0, g1);

      // Abandoned lock: m0 locks, then drops req; pending m1 wins that cycle.
      rst = 1'b1; step(g0, g1); rst = 1'b0;
      set_m0(1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
      set_m1(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
      repeat (2) step(g0, g1);
      set_m0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      step(g0, g1);
      idle_both();
      repeat (4) step(g0, g1);

      // Reset in the cycle after a granted read: response discarded.
      set_m0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
      step(g0, g1);
      rst = 1'b1;
      set_m1(1'b1, 4'h0, 32'hC, 32'h0, 1'b0);
      repeat (2) step(g0, g1);
      rst = 1'b0;
      step(g0, g1);
      idle_both();
      repeat (4) step(g0, g1);

      // Back-to-back reads from m0: responses in issue order, one per cycle.
      for (int i = 0; i < 3; i++) begin
         set_m0(1'b1, 4'h0, 32'(4 * i), 32'h0, 1'b0);
         step(g0, g1);
      end
      idle_both();
      repeat (5) step(g0, g1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
